// File: rtl/tdc_timestamp_builder_pkg.sv
// tdc_timestamp_builder_pkg: shared widths, defaults and word-source encoding for the TDC timestamp builder
package tdc_timestamp_builder_pkg;
    localparam int FINE_WIDTH = 5;
    localparam int DEF_COARSE_WIDTH = 11;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam logic [FINE_WIDTH-1:0] MARKER_FINE = '0;

    typedef enum logic [1:0] {SRC_NONE, SRC_HIT, SRC_MARKER} word_src_e;

    function automatic int marker_tag_pos(input int coarse_width);
        return coarse_width + FINE_WIDTH;
    endfunction
endpackage

// File: rtl/tdc_timestamp_builder_sync_fifo.sv
// tdc_sync_fifo: synchronous FIFO with registered pointers, occupancy count and fall-through head
module tdc_sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && (!count_q[AW] || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign valid = count_q != '0;
    assign full  = count_q[AW];
    assign count = count_q;
endmodule

// File: rtl/tdc_timestamp_builder.sv
// tdc_timestamp_builder: coarse counter, hit/rollover-marker arbitration, sticky overflow and output FIFO
module tdc_timestamp_builder
    import tdc_timestamp_builder_pkg::*;
#(
    parameter int COARSE_WIDTH = DEF_COARSE_WIDTH,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic                               hit_valid,
    input  logic [FINE_WIDTH-1:0]              fine,
    input  logic                               clr_ovf,
    input  logic                               out_ready,
    output logic                               out_valid,
    output logic [COARSE_WIDTH+FINE_WIDTH:0]   out_data,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_count,
    output logic                               ovf
);
    localparam int W = marker_tag_pos(COARSE_WIDTH) + 1;

    logic [COARSE_WIDTH-1:0] coarse_q, coarse_d;
    logic                    pending_q, pending_d;
    logic                    ovf_q, ovf_d;
    word_src_e               src;
    logic                    wrap, pop, room, push, full;
    logic [W-1:0]            push_data;

    // A hit always wins the write slot; the marker waits for a hit-free cycle with room
    always_comb begin
        wrap      = en && (coarse_q == '1);
        coarse_d  = en ? coarse_q + COARSE_WIDTH'(1) : coarse_q;
        src       = (en && hit_valid) ? SRC_HIT : pending_q ? SRC_MARKER : SRC_NONE;
        pop       = out_valid && out_ready;
        room      = !full || pop;
        push      = (src != SRC_NONE) && room;
        push_data = (src == SRC_HIT) ? {1'b0, coarse_q, fine} : {1'b1, {COARSE_WIDTH{1'b1}}, MARKER_FINE};
        pending_d = wrap || (pending_q && !((src == SRC_MARKER) && room));
        ovf_d     = ((src == SRC_HIT) && !room) || (ovf_q && !clr_ovf);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coarse_q  <= '0;
            pending_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            coarse_q  <= coarse_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    tdc_sync_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (out_data),
        .valid     (out_valid),
        .full      (full),
        .count     (fifo_count)
    );

    assign ovf = ovf_q;
endmodule

// File: tb/tb_tdc_timestamp_builder.sv
// tb_tdc_timestamp_builder: directed scenario tests for the TDC timestamp builder
module tb_tdc_timestamp_builder;
    logic        clk = 1'b0;
    logic        rst, en, hit_valid, clr_ovf, out_ready;
    logic [4:0]  fine;
    logic        out_valid, ovf;
    logic [16:0] out_data;
    logic [3:0]  fifo_count;
    int          tests = 0;
    int          failures = 0;

    tdc_timestamp_builder dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .hit_valid  (hit_valid),
        .fine       (fine),
        .clr_ovf    (clr_ovf),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .fifo_count (fifo_count),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; hit_valid = 1'b0; fine = '0; clr_ovf = 1'b0; out_ready = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; hit_valid = 1'b1; fine = 5'd9; clr_ovf = 1'b0; out_ready = 1'b0;
        cycle();
        cycle();
        rst = 1'b0; hit_valid = 1'b0; en = 1'b0;
        tests++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        tests++; if (fifo_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        tests++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    endtask

    task automatic test_single_hit();
        do_reset();
        en = 1'b1;
        repeat (5) cycle();
        hit_valid = 1'b1; fine = 5'd13;
        cycle();
        hit_valid = 1'b0;
        tests++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        tests++; if (out_data !== {1'b0, 11'd5, 5'd13}) begin failures++; $display("FAIL single_data got=%h exp=%h", out_data, {1'b0, 11'd5, 5'd13}); end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_pop got=%b exp=0", out_valid); end
    endtask

    task automatic test_en_hold();
        do_reset();
        en = 1'b1;
        repeat (3) cycle();
        en = 1'b0; hit_valid = 1'b1; fine = 5'd4;
        repeat (4) cycle();
        tests++; if (fifo_count !== 4'd0) begin failures++; $display("FAIL en_low_hits got=%0d exp=0", fifo_count); end
        en = 1'b1; fine = 5'd9;
        cycle();
        hit_valid = 1'b0;
        tests++; if (out_data !== {1'b0, 11'd3, 5'd9}) begin failures++; $display("FAIL en_hold_coarse got=%h exp=%h", out_data, {1'b0, 11'd3, 5'd9}); end
    endtask

    task automatic test_wrap();
        do_reset();
        en = 1'b1;
        repeat (2047) cycle();
        hit_valid = 1'b1; fine = 5'd3;
        cycle();
        hit_valid = 1'b0;
        tests++; if (out_data !== {1'b0, 11'd2047, 5'd3}) begin failures++; $display("FAIL wrap_hit got=%h exp=%h", out_data, {1'b0, 11'd2047, 5'd3}); end
        cycle();
        tests++; if (fifo_count !== 4'd2) begin failures++; $display("FAIL wrap_count got=%0d exp=2", fifo_count); end
        out_ready = 1'b1;
        cycle();
        tests++; if (out_data !== {1'b1, 11'd2047, 5'd0}) begin failures++; $display("FAIL wrap_marker got=%h exp=%h", out_data, {1'b1, 11'd2047, 5'd0}); end
        cycle();
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0) begin failures++; $display("FAIL wrap_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_overflow();
        logic [16:0] exp_w;
        do_reset();
        en = 1'b1; hit_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            fine = 5'(i + 1);
            cycle();
        end
        hit_valid = 1'b0;
        tests++; if (fifo_count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", fifo_count); end
        tests++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", ovf); end
        hit_valid = 1'b1; clr_ovf = 1'b1; fine = 5'd30;
        cycle();
        hit_valid = 1'b0;
        tests++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_drop_wins got=%b exp=1", ovf); end
        cycle();
        clr_ovf = 1'b0;
        tests++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_w = {1'b0, 11'(i), 5'(i + 1)};
            tests++; if (out_data !== exp_w) begin failures++; $display("FAIL ovf_word%0d got=%h exp=%h", i, out_data, exp_w); end
            cycle();
        end
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [16:0] exp_w;
        do_reset();
        en = 1'b1; hit_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            fine = 5'(i);
            cycle();
        end
        out_ready = 1'b1; fine = 5'd20;
        cycle();
        hit_valid = 1'b0;
        tests++; if (fifo_count !== 4'd8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", fifo_count); end
        tests++; if (ovf !== 1'b0) begin failures++; $display("FAIL b2b_ovf got=%b exp=0", ovf); end
        for (int j = 1; j <= 8; j++) begin
            exp_w = {1'b0, 11'(j), (j == 8) ? 5'd20 : 5'(j)};
            tests++; if (out_data !== exp_w) begin failures++; $display("FAIL b2b_word%0d got=%h exp=%h", j, out_data, exp_w); end
            cycle();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_wrap_full();
        logic [16:0] exp_w;
        do_reset();
        en = 1'b1;
        repeat (2040) cycle();
        hit_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            fine = 5'(i);
            cycle();
        end
        hit_valid = 1'b0;
        repeat (5) cycle();
        tests++; if (fifo_count !== 4'd8) begin failures++; $display("FAIL wfull_hold got=%0d exp=8", fifo_count); end
        tests++; if (ovf !== 1'b0) begin failures++; $display("FAIL wfull_ovf got=%b exp=0", ovf); end
        out_ready = 1'b1;
        cycle();
        tests++; if (fifo_count !== 4'd8) begin failures++; $display("FAIL wfull_swap got=%0d exp=8", fifo_count); end
        for (int i = 1; i <= 8; i++) begin
            exp_w = (i == 8) ? {1'b1, 11'd2047, 5'd0} : {1'b0, 11'(2040 + i), 5'(i)};
            tests++; if (out_data !== exp_w) begin failures++; $display("FAIL wfull_word%0d got=%h exp=%h", i, out_data, exp_w); end
            cycle();
        end
        out_ready = 1'b0;
        tests++; if (ovf !== 1'b0) begin failures++; $display("FAIL wfull_ovf_end got=%b exp=0", ovf); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 1'b1; hit_valid = 1'b1; fine = 5'd1;
        repeat (4) cycle();
        hit_valid = 1'b0;
        tests++; if (fifo_count !== 4'd4) begin failures++; $display("FAIL rmid_pre got=%0d exp=4", fifo_count); end
        rst = 1'b1; hit_valid = 1'b1;
        cycle();
        rst = 1'b0; hit_valid = 1'b0;
        tests++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", out_valid); end
        tests++; if (fifo_count !== 4'd0) begin failures++; $display("FAIL rmid_count got=%0d exp=0", fifo_count); end
        hit_valid = 1'b1; fine = 5'd7;
        cycle();
        hit_valid = 1'b0;
        tests++; if (out_data !== {1'b0, 11'd0, 5'd7}) begin failures++; $display("FAIL rmid_coarse got=%h exp=%h", out_data, {1'b0, 11'd0, 5'd7}); end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_en_hold();
        test_wrap();
        test_overflow();
        test_back_to_back();
        test_wrap_full();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
